burst_line_master: RTL and testbench

- Initiator for the burst memory command interface (cmd/cmd_en/addr/wr_data/data_mask/rd_data/rd_data_valid/busy).
- Converts single whole-line requests from the cache into one memory burst.
  - Read: assembles BURST_COUNT read beats into one line.
  - Write: serialises a line into BURST_COUNT write beats.
- Sits between the cache controller and the burst RAM / PSRAM controller.

---
 rtl/burst_line_master.sv | 138 +++++++++++++
 tb/tb_burst_line_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/burst_line_master.sv
// burst_line_master: turns whole-line cache requests into single bursts on a burst memory command port
// Ports:
//   clk, rst_n                            clock, asynchronous active-low reset
//   req_valid/req_ready/req_write         line request handshake and direction (1 = write)
//   req_line_addr, req_wr_line            line address and write line (beat 0 in the LSBs)
//   rsp_valid/rsp_error/rsp_rd_line       one-cycle completion, read-timeout flag, assembled read line
//   cmd/cmd_en/addr/wr_data/data_mask     memory command side (cmd 1 = write)
//   rd_data/rd_data_valid/busy            memory read beats and not-ready indication
module burst_line_master #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH = 64,
  parameter int BURST_COUNT = 4,
  parameter int RD_TIMEOUT_CYCLES = 64
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            req_valid,
  output logic                                            req_ready,
  input  logic                                            req_write,
  input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0]   req_line_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]            req_wr_line,
  output logic                                            rsp_valid,
  output logic                                            rsp_error,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0]            rsp_rd_line,
  output logic                                            cmd,
  output logic                                            cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]                       addr,
  output logic [DATA_BITWIDTH-1:0]                        wr_data,
  output logic [DATA_BITWIDTH/8-1:0]                      data_mask,
  input  logic [DATA_BITWIDTH-1:0]                        rd_data,
  input  logic                                            rd_data_valid,
  input  logic                                            busy
);
  localparam int LW = $clog2(BURST_COUNT);
  localparam int TW = $clog2(RD_TIMEOUT_CYCLES + 1);
  localparam int LINE_W = DATA_BITWIDTH * BURST_COUNT;
  localparam int REST_W = LINE_W - DATA_BITWIDTH;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_BURST, RESP} state_e;
  state_e                    state_q, state_d;
  logic [LW-1:0]             beat_q, beat_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic                      cmd_q, cmd_d;
  logic                      cmd_en_q, cmd_en_d;
  logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
  logic [DATA_BITWIDTH-1:0]  wr_data_q, wr_data_d;
  // beats still to be driven after the current one, next beat in the LSBs
  logic [REST_W-1:0]         wr_rest_q, wr_rest_d;
  logic                      rsp_error_q, rsp_error_d;
  logic [LINE_W-1:0]         rd_line_q, rd_line_d;
  // rst_n gates req_ready so nothing is accepted while reset is held
  assign req_ready   = rst_n && (state_q == IDLE) && !busy;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_error   = rsp_valid && rsp_error_q;
  assign rsp_rd_line = rd_line_q;
  assign cmd         = cmd_q;
  assign cmd_en      = cmd_en_q;
  assign addr        = addr_q;
  assign wr_data     = wr_data_q;
  assign data_mask   = '0;
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    cmd_en_d    = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_rest_d   = wr_rest_q;
    rsp_error_d = rsp_error_q;
    rd_line_d   = rd_line_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d     = req_write ? WR_BURST : RD_WAIT;
          cmd_en_d    = 1'b1;
          cmd_d       = req_write;
          addr_d      = {req_line_addr, {LW{1'b0}}};
          beat_d      = '0;
          tmo_d       = '0;
          rsp_error_d = 1'b0;
          if (req_write) begin
            wr_data_d = req_wr_line[DATA_BITWIDTH-1:0];
            wr_rest_d = req_wr_line[LINE_W-1:DATA_BITWIDTH];
          end
        end
      end
      RD_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (rd_data_valid) begin
          rd_line_d[int'(beat_q)*DATA_BITWIDTH +: DATA_BITWIDTH] = rd_data;
          beat_d = beat_q + LW'(1);
        end
        // a last beat arriving on the timeout cycle still completes cleanly
        if (rd_data_valid && beat_q == LW'(BURST_COUNT - 1)) begin
          state_d = RESP;
        end else if (tmo_q == TW'(RD_TIMEOUT_CYCLES)) begin
          state_d     = RESP;
          rsp_error_d = 1'b1;
        end
      end
      WR_BURST: begin
        if (beat_q == LW'(BURST_COUNT - 1)) begin
          state_d = RESP;
        end else begin
          beat_d    = beat_q + LW'(1);
          wr_data_d = wr_rest_q[DATA_BITWIDTH-1:0];
          wr_rest_d = wr_rest_q >> DATA_BITWIDTH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      tmo_q       <= '0;
      cmd_q       <= 1'b0;
      cmd_en_q    <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_rest_q   <= '0;
      rsp_error_q <= 1'b0;
      rd_line_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      cmd_en_q    <= cmd_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_rest_q   <= wr_rest_d;
      rsp_error_q <= rsp_error_d;
      rd_line_q   <= rd_line_d;
    end
  end
endmodule

// File: tb/tb_burst_line_master.sv
// tb_burst_line_master: directed bench with a burst RAM model for burst_line_master
module tb_burst_line_master;
  localparam int TMO = 64;
  logic         clk = 1'b0;
  logic         rst_n, req_valid, req_ready, req_write;
  logic [1:0]   req_line_addr;
  logic [255:0] req_wr_line, rsp_rd_line;
  logic         rsp_valid, rsp_error, cmd, cmd_en;
  logic [3:0]   addr;
  logic [63:0]  wr_data, rd_data;
  logic [7:0]   data_mask;
  logic         rd_data_valid, busy;
  localparam logic [255:0] L0 = {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4, 64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980};
  localparam logic [255:0] L1 = {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7, 64'hE1A7D0B5C8F3E6A9, 64'h6C4B9A8D2F5E3C7A};
  localparam logic [255:0] LW1 = {64'd4, 64'd3, 64'd2, 64'd1};
  int n_cmp = 0, n_bad = 0, cyc = 0;
  burst_line_master #(.DEPTH_BITWIDTH(4), .DATA_BITWIDTH(64), .BURST_COUNT(4), .RD_TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line_addr(req_line_addr), .req_wr_line(req_wr_line), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
    .rsp_rd_line(rsp_rd_line), .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data),
    .data_mask(data_mask), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // burst RAM model, acts on the falling edge so its drives never race the DUT
  logic [63:0] mem [0:15] = '{64'h3F5A2E14B7C6A980, 64'h9D8E2F17AB4C3E6F, 64'hA1C3F7E2D5B8A9C4, 64'h7D4E9F2C1B6A3D8F,
                              64'h6C4B9A8D2F5E3C7A, 64'hE1A7D0B5C8F3E6A9, 64'hF8E9D2C3B4A5F6E7, 64'hD4E7F2C5B8A3D6E9,
                              64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
  logic [63:0] wlog [0:3];
  int          wcyc [0:3];
  logic [3:0]  r_ptr, w_ptr;
  int r_left = 0, r_delay = 0, w_left = 0, beats_total = 0, last_beat_cyc = 0, mask_bad = 0;
  int stray_done = 0;
  int stray_n = 0;
  bit mute = 1'b0;
  initial begin
    rd_data = '0;
    rd_data_valid = 1'b0;
  end
  always @(negedge clk) begin
    rd_data_valid = 1'b0;
    if (!rst_n) begin
      r_left = 0;
      w_left = 0;
    end else begin
      if (cmd_en && cmd) begin
        mem[addr] = wr_data; wlog[0] = wr_data; wcyc[0] = cyc; w_ptr = addr + 4'd1; w_left = 3;
        if (data_mask != 8'h0) mask_bad++;
      end else if (w_left > 0) begin
        mem[w_ptr] = wr_data; wlog[4-w_left] = wr_data; wcyc[4-w_left] = cyc; w_ptr++; w_left--;
        if (data_mask != 8'h0) mask_bad++;
      end
      if (cmd_en && !cmd && !mute) begin
        r_ptr = addr; r_left = 4; r_delay = 2;
      end else if (r_left > 0) begin
        if (r_delay > 0) r_delay--;
        else begin
          rd_data_valid = 1'b1; rd_data = mem[r_ptr]; r_ptr++; r_left--; beats_total++; last_beat_cyc = cyc;
          r_delay = (r_left == 2) ? 1 : 0;
        end
      end else if (stray_n > stray_done) begin
        rd_data_valid = 1'b1; rd_data = 64'hDEADBEEFCAFEF00D; stray_done++;
      end
    end
  end
  int cmd_cnt = 0, cmd_cyc = 0, busy_viol = 0, rsp_cnt = 0, rsp_cyc = 0, rsp_multi = 0;
  logic [3:0] cmd_addr = '0;
  logic cmd_kind = 1'b0, rsp_err = 1'b0, rsp_prev = 1'b0;
  always @(negedge clk) begin
    if (cmd_en) begin
      cmd_cnt++; cmd_cyc = cyc; cmd_addr = addr; cmd_kind = cmd;
      if (busy) busy_viol++;
    end
    if (rsp_valid) begin
      if (rsp_prev) rsp_multi++;
      rsp_cnt++; rsp_cyc = cyc; rsp_err = rsp_error;
    end
    rsp_prev = rsp_valid;
  end
  task automatic do_req(input logic wr, input logic [1:0] line, input logic [255:0] data);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = wr; req_line_addr = line; req_wr_line = data;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge clk);
      #1 ok = (rsp_cnt > base);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; busy = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_line_addr = '0; req_wr_line = '0;
    #3;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if ({cmd_en, cmd, rsp_valid, rsp_error} !== 4'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 0000", {cmd_en, cmd, rsp_valid, rsp_error}); end
    n_cmp++; if ({addr, wr_data, data_mask} !== 76'h0) begin n_bad++; $display("FAIL reset_cmd_bus: got %h want 0", {addr, wr_data, data_mask}); end
    n_cmp++; if (rsp_rd_line !== 256'h0) begin n_bad++; $display("FAIL reset_rd_line: got %h want 0", rsp_rd_line); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL busy_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    req_valid = 1'b0;
    @(negedge clk);
    busy = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_busy: got %b want 1", req_ready); end
    n_cmp++; if (cmd_cnt !== 0) begin n_bad++; $display("FAIL cmd_en_during_busy: got %0d want 0", cmd_cnt); end
  endtask
  task automatic test_read(input logic [1:0] line, input logic [255:0] exp);
    int bc = cmd_cnt, br = rsp_cnt;
    bit ok;
    do_req(1'b0, line, '0);
    wait_rsp(br, 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd%0d_rsp_seen: got none want rsp_valid", line); end
    n_cmp++; if (cmd_cnt - bc !== 1) begin n_bad++; $display("FAIL rd%0d_cmd_en_count: got %0d want 1", line, cmd_cnt - bc); end
    n_cmp++; if ({cmd_kind, cmd_addr} !== {1'b0, line, 2'b00}) begin n_bad++; $display("FAIL rd%0d_cmd_addr: got %b/%h want 0/%h", line, cmd_kind, cmd_addr, {line, 2'b00}); end
    n_cmp++; if (rsp_cyc !== last_beat_cyc + 1) begin n_bad++; $display("FAIL rd%0d_rsp_latency: got %0d want %0d", line, rsp_cyc, last_beat_cyc + 1); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd%0d_rsp_error: got %b want 0", line, rsp_err); end
    n_cmp++; if (rsp_rd_line !== exp) begin n_bad++; $display("FAIL rd%0d_line: got %h want %h", line, rsp_rd_line, exp); end
    n_cmp++; if (rsp_multi !== 0) begin n_bad++; $display("FAIL rd%0d_rsp_width: got %0d extra cycles want 0", line, rsp_multi); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rd%0d_back_idle: got %b want 1", line, req_ready); end
  endtask
  task automatic test_write;
    int bc = cmd_cnt, br = rsp_cnt;
    bit ok;
    do_req(1'b1, 2'd1, LW1);
    wait_rsp(br, 30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_rsp_seen: got none want rsp_valid"); end
    n_cmp++; if (cmd_cnt - bc !== 1) begin n_bad++; $display("FAIL wr_cmd_en_count: got %0d want 1", cmd_cnt - bc); end
    n_cmp++; if ({cmd_kind, cmd_addr} !== 5'b1_0100) begin n_bad++; $display("FAIL wr_cmd_addr: got %b/%h want 1/4", cmd_kind, cmd_addr); end
    n_cmp++; if (wcyc[0] !== cmd_cyc) begin n_bad++; $display("FAIL wr_beat0_with_cmd_en: got %0d want %0d", wcyc[0], cmd_cyc); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (wlog[k] !== 64'(k + 1)) begin n_bad++; $display("FAIL wr_beat%0d_data: got %h want %h", k, wlog[k], 64'(k + 1)); end
      n_cmp++; if (wcyc[k] !== wcyc[0] + k) begin n_bad++; $display("FAIL wr_beat%0d_cycle: got %0d want %0d", k, wcyc[k], wcyc[0] + k); end
    end
    n_cmp++; if (mask_bad !== 0) begin n_bad++; $display("FAIL wr_data_mask: got %0d nonzero beats want 0", mask_bad); end
    n_cmp++; if (rsp_cyc !== wcyc[3] + 1) begin n_bad++; $display("FAIL wr_rsp_latency: got %0d want %0d", rsp_cyc, wcyc[3] + 1); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_error: got %b want 0", rsp_err); end
    n_cmp++; if (rsp_rd_line !== L1) begin n_bad++; $display("FAIL wr_keeps_rd_line: got %h want %h", rsp_rd_line, L1); end
  endtask
  task automatic test_timeout;
    int br = rsp_cnt;
    bit ok;
    mute = 1'b1;
    do_req(1'b0, 2'd2, '0);
    wait_rsp(br, 120, ok);
    mute = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_rsp_seen: got none want rsp_valid"); end
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL tmo_rsp_error: got %b want 1", rsp_err); end
    n_cmp++; if (rsp_cyc - cmd_cyc !== TMO + 1) begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", rsp_cyc - cmd_cyc, TMO + 1); end
    n_cmp++; if (rsp_rd_line !== LW1) begin n_bad++; $display("FAIL tmo_partial_line: got %h want %h", rsp_rd_line, LW1); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_back_idle: got %b want 1", req_ready); end
    stray_n++;
    repeat (3) @(negedge clk);
    n_cmp++; if (rsp_rd_line !== LW1 || rsp_cnt !== br + 1) begin n_bad++; $display("FAIL stray_rd_valid: got %h/%0d want %h/%0d", rsp_rd_line, rsp_cnt, LW1, br + 1); end
  endtask
  task automatic test_reset_mid_burst;
    int bb = beats_total, br = rsp_cnt, n = 0;
    do_req(1'b0, 2'd0, '0);
    while (beats_total - bb < 2 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    n_cmp++; if (beats_total - bb !== 2) begin n_bad++; $display("FAIL mid_two_beats: got %0d want 2", beats_total - bb); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({req_ready, cmd_en, cmd, rsp_valid, rsp_error, addr} !== 9'h0) begin n_bad++; $display("FAIL mid_reset_outputs: got %h want 0", {req_ready, cmd_en, cmd, rsp_valid, rsp_error, addr}); end
    n_cmp++; if ({rsp_rd_line, wr_data} !== 320'h0) begin n_bad++; $display("FAIL mid_reset_data: got %h want 0", rsp_rd_line); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rsp_cnt !== br) begin n_bad++; $display("FAIL mid_no_rsp: got %0d want %0d", rsp_cnt, br); end
    test_read(2'd0, L0);
  endtask
  initial begin
    test_reset;
    test_read(2'd0, L0);
    test_read(2'd1, L1);
    test_write;
    test_read(2'd1, LW1);
    test_timeout;
    test_reset_mid_burst;
    n_cmp++; if (busy_viol !== 0) begin n_bad++; $display("FAIL cmd_en_while_busy: got %0d want 0", busy_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
